serial_pattern_detector: RTL
============================

Name: serial_pattern_detector

Overview:
- Receive-side counterpart to the serial single-bit stimulus streams driven onto D-flip-flop inputs in the week-11 lab.
- Samples one serial bit per qualified clock and detects a programmable PAT_LEN-bit pattern (MSB received first).
- Emits a registered one-cycle match pulse and keeps a saturating match count.
- Sits directly downstream of a serial bit source (flip-flop chain or bench driver) as the decoding and checking end.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, target pattern. Bit PAT_LEN-1 is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of history, fill count, match and counter.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only on cycles where this is high.
- match  output  1  one-cycle pulse when the pattern completes.
- match_cnt  output  CNT_W  number of matches detected, saturating.
- hist  output  PAT_LEN  shift history; the newest bit is at bit 0.
- primed  output  1  high once PAT_LEN valid bits are held since the last reset, clear or restart.

Behaviour:
- One clock and one reset domain only. rst_n is asynchronous active-low.
- Reset values (rst_n low): hist=0, fill count=0, primed=0, match=0, match_cnt=0. These hold while rst_n is low.
- Per rising edge, in priority order:
  - clr=1: all registers return to their reset values. din_valid is ignored that cycle.
  - din_valid=1: next_hist = {hist[PAT_LEN-2:0], din}. The fill counter increments and saturates at PAT_LEN.
  - din_valid=0: hist, fill and counter hold. match is driven 0.
- Match condition, evaluated on the accepting edge: next_hist == PATTERN and the fill count after this bit is >= PAT_LEN.
- Latency: match is high exactly in the cycle after the edge that accepted the final pattern bit. It is never high for two consecutive cycles unless two consecutive valid bits each complete a match. That can only happen with overlap and periodic patterns such as 2'b11.
- No false matches from the zeroed reset history. For example, PATTERN=4'b0000 cannot match before 4 valid bits have been received.
- match_cnt increments by 1 on each match edge and saturates at 2^CNT_W-1. It does not wrap.
- primed = (fill count == PAT_LEN).
- Restart after a match is defined under Optional Feature.
- Reset mid-stream: a partial pattern is discarded. Detection restarts from an empty history.
- Valid gaps: any number of din_valid=0 cycles between bits does not break a pattern.
- FSM view, state = fill count: EMPTY(0) -> FILLING(1..PAT_LEN-1) -> PRIMED(PAT_LEN).
  - PRIMED holds on valid bits.
  - clr or reset returns the FSM to EMPTY.

Optional Feature:
- Macro: SERIAL_PATTERN_DETECTOR_OVERLAP_EN.
- Defined: overlapping detection. After a match, hist and the fill count are retained, so the suffix of one match may start the next.
- Undefined: non-overlapping detection.
  - On a match edge, the fill count is set to 0 and primed drops.
  - hist is still updated with the bit.
  - A further PAT_LEN fresh valid bits are needed before the next match.

Test Plan:
- Reset, then valid bits 1,0,1,1 on consecutive cycles: match high for one cycle after the 4th bit; match_cnt=1; hist=4'b1011; primed=1.
- Bits 1,0,1,1,0,1,1:
  - With OVERLAP_EN: two match pulses (after bits 4 and 7); match_cnt=2.
  - Without OVERLAP_EN: one pulse; match_cnt=1; primed=0 after bit 4 and still 0 after bit 7.
- Bits 1,0,1,1 with 3 din_valid=0 cycles inserted between each bit, din toggling during the gaps: exactly one match after the 4th valid bit; hist unchanged during the gaps.
- rst_n pulsed low asynchronously (mid-cycle) after bits 1,0,1, then bit 1 sent: outputs zero immediately; no match; match_cnt=0; primed=0.
- CNT_W=2 with 5 separate 1011 sequences: match_cnt reads 1,2,3,3,3. Then clr=1 together with din_valid=1: match_cnt=0, hist=0, primed=0, and that bit is ignored.
- PATTERN=4'b0000: reset, then 3 valid zeros gives no match; the 4th zero gives a match.

Source files
------------

// File: rtl/serial_pattern_detector.sv
// Serial PAT_LEN-bit pattern detector (MSB first) with a match pulse, a saturating match count and fill tracking.
// Define SERIAL_PATTERN_DETECTOR_OVERLAP_EN for overlapping detection; the default build is non-overlapping.
module serial_pattern_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               din,
   input  logic               din_valid,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt,
   output logic [PAT_LEN-1:0] hist,
   output logic               primed
);

   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_PRIMED  = 2'd2
   } state_t;

   state_t              r_state;
   logic [FILL_W-1:0]   r_fill;
   logic [PAT_LEN-1:0]  r_hist;
   logic                r_match;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_primed;

   logic [PAT_LEN-1:0]  w_next_hist;
   logic [FILL_W-1:0]   w_fill_inc;
   logic [FILL_W-1:0]   w_fill_next;
   logic                w_hit;
   logic [CNT_W-1:0]    w_cnt_next;
   state_t              w_state_next;

   // Next-state decode for an accepted bit: shifted history, fill count, hit and counter.
   always_comb begin
      w_next_hist = {r_hist[PAT_LEN-2:0], din};
      if (r_state == ST_PRIMED) begin
         w_fill_inc = r_fill;
      end else begin
         w_fill_inc = r_fill + FILL_ONE;
      end
      // The fill gate keeps the zeroed reset history from producing a false hit.
      w_hit = (w_next_hist == PATTERN) && (w_fill_inc == FILL_FULL);
`ifdef SERIAL_PATTERN_DETECTOR_OVERLAP_EN
      w_fill_next = w_fill_inc;
`else
      if (w_hit) begin
         w_fill_next = {FILL_W{1'b0}};
      end else begin
         w_fill_next = w_fill_inc;
      end
`endif
      if (w_fill_next == {FILL_W{1'b0}}) begin
         w_state_next = ST_EMPTY;
      end else if (w_fill_next == FILL_FULL) begin
         w_state_next = ST_PRIMED;
      end else begin
         w_state_next = ST_FILLING;
      end
      if (w_hit && (r_cnt != CNT_MAX)) begin
         w_cnt_next = r_cnt + CNT_ONE;
      end else begin
         w_cnt_next = r_cnt;
      end
   end

   // Fill FSM, history shift register, match pulse and saturating counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_EMPTY;
         r_fill   <= {FILL_W{1'b0}};
         r_hist   <= {PAT_LEN{1'b0}};
         r_match  <= 1'b0;
         r_cnt    <= {CNT_W{1'b0}};
         r_primed <= 1'b0;
      end else if (clr) begin
         r_state  <= ST_EMPTY;
         r_fill   <= {FILL_W{1'b0}};
         r_hist   <= {PAT_LEN{1'b0}};
         r_match  <= 1'b0;
         r_cnt    <= {CNT_W{1'b0}};
         r_primed <= 1'b0;
      end else if (din_valid) begin
         r_state  <= w_state_next;
         r_fill   <= w_fill_next;
         r_hist   <= w_next_hist;
         r_match  <= w_hit;
         r_cnt    <= w_cnt_next;
         r_primed <= (w_fill_next == FILL_FULL);
      end else begin
         r_match  <= 1'b0;
      end
   end

   assign match     = r_match;
   assign match_cnt = r_cnt;
   assign hist      = r_hist;
   assign primed    = r_primed;

endmodule
